// File: rtl/asip_pkg.sv
// Shared types and constants for the MAX/MIN/AVG ASIP: sequencer states,
// memory geometry used by the ControlUnit and the HALT opcode.
package asip_pkg;

   localparam int unsigned ASIP_ADDR_W = 8;
   localparam int unsigned ASIP_DATA_W = 8;

   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      CORE_RST,
      RUN,
      DONE,
      ERR
   } seq_state_t;

   // Host owns the shared memory whenever the core is not being reset or run.
   function automatic logic host_owns(input seq_state_t s);
      return (s == IDLE) || (s == DONE) || (s == ERR);
   endfunction

endpackage

// File: rtl/asip_run_counter.sv
// Job timing for the run sequencer: core-reset countdown, saturating
// RUN-cycle counter and the watchdog compare.
module asip_run_counter #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned WDT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic             load,
   output logic [CNT_W-1:0] count,
   output logic             rst_done,
   output logic             wdt_hit
);

   localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   logic [CNT_W-1:0] count_q, count_d;
   logic [RC_W-1:0]  rc_q, rc_d;

   always_comb begin
      count_d = count_q;
      rc_d    = rc_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
      if (load) begin
         rc_d = RC_W'(RST_CYCLES - 1);
      end else if (rc_q != '0) begin
         rc_d = rc_q - RC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         rc_q    <= '0;
      end else begin
         count_q <= count_d;
         rc_q    <= rc_d;
      end
   end

   assign count    = count_q;
   assign rst_done = (rc_q == '0);
   // Fires in the RUN cycle whose increment brings the count to WDT_CYCLES.
   assign wdt_hit  = (64'(count_q) + 64'd1) >= 64'(WDT_CYCLES);

endmodule

// File: rtl/asip_run_sequencer.sv
// Run controller and memory arbiter for the ASIP: sequences host preload,
// core reset, core run, halt/watchdog and readback over one shared memory.
module asip_run_sequencer
   import asip_pkg::*;
#(
   parameter int unsigned ADDR_W     = ASIP_ADDR_W,
   parameter int unsigned DATA_W     = ASIP_DATA_W,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned WDT_CYCLES = 4096,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              Start,
   output logic              Busy,
   output logic              Done,
   output logic              Error,
   output logic [CNT_W-1:0]  Run_cycles,
   input  logic              Host_req,
   input  logic              Host_we,
   input  logic [ADDR_W-1:0] Host_addr,
   input  logic [DATA_W-1:0] Host_wdata,
   output logic              Host_grant,
   output logic [DATA_W-1:0] Host_rdata,
   output logic              Host_rvalid,
   output logic              Core_reset,
   output logic              Core_run,
   input  logic              Core_halt,
   input  logic [ADDR_W-1:0] Core_addr,
   input  logic [DATA_W-1:0] Core_wdata,
   input  logic              Core_we,
   output logic [DATA_W-1:0] Core_rdata,
   output logic [ADDR_W-1:0] Mem_addr,
   output logic [DATA_W-1:0] Mem_wdata,
   output logic              Mem_we,
   input  logic [DATA_W-1:0] Mem_rdata
);

   seq_state_t state_q, state_d;

   logic              host_sel;
   logic              job_start;
   logic              cnt_enable;
   logic              rst_done;
   logic              wdt_hit;
   logic              rvalid_q, rvalid_d;
   logic              fresh_q, fresh_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   asip_run_counter #(
      .CNT_W      (CNT_W),
      .RST_CYCLES (RST_CYCLES),
      .WDT_CYCLES (WDT_CYCLES)
   ) u_run_counter (
      .clk      (CLK),
      .rst      (RESET),
      .clear    (job_start),
      .enable   (cnt_enable),
      .load     (job_start),
      .count    (Run_cycles),
      .rst_done (rst_done),
      .wdt_hit  (wdt_hit)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERR: if (Start) state_d = CORE_RST;
         CORE_RST:        if (rst_done) state_d = RUN;
         RUN: begin
            if (Core_halt) begin
               state_d = DONE;
            end else if (wdt_hit) begin
               state_d = ERR;
            end
         end
         default:         state_d = IDLE;
      endcase
   end

   always_comb begin
      host_sel   = host_owns(state_q);
      Busy       = (state_q == CORE_RST) || (state_q == RUN);
      Done       = (state_q == DONE);
      Error      = (state_q == ERR);
      Core_reset = (state_q == IDLE) || (state_q == CORE_RST);
      Core_run   = (state_q == RUN);
      cnt_enable = (state_q == RUN);
      job_start  = host_sel && Start;
      Host_grant = host_sel && Host_req && !RESET;
      Mem_addr   = Core_addr;
      Mem_wdata  = Core_wdata;
      Mem_we     = 1'b0;
      if (host_sel) begin
         Mem_addr  = Host_addr;
         Mem_wdata = Host_wdata;
         Mem_we    = Host_req && Host_we && !RESET;
      end else if (state_q == RUN) begin
         Mem_we    = Core_we && !RESET;
      end
   end

   // Read return: fresh_q marks the cycle the macro presents the granted
   // read; the data is forwarded then and held in rdata_q afterwards.
   always_comb begin
      rvalid_d = rvalid_q;
      fresh_d  = 1'b0;
      rdata_d  = rdata_q;
      if (fresh_q) rdata_d = Mem_rdata;
      if (Host_grant) begin
         rvalid_d = !Host_we;
         fresh_d  = !Host_we;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rvalid_q <= 1'b0;
         fresh_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         fresh_q  <= fresh_d;
         rdata_q  <= rdata_d;
      end
   end

   assign Host_rvalid = rvalid_q;
   assign Host_rdata  = fresh_q ? Mem_rdata : rdata_q;
   assign Core_rdata  = Mem_rdata;

endmodule

// File: tb/tb_asip_run_sequencer.sv
// Self-checking bench for asip_run_sequencer: host handshake table, directed
// job sequences and randomized traffic against a behavioural job model.
module tb_asip_run_sequencer;

   localparam int unsigned AW   = 8;
   localparam int unsigned DW   = 8;
   localparam int unsigned RSTC = 2;
   localparam int unsigned WDT  = 64;
   localparam int unsigned CW   = 16;
   localparam int          CNT_MAX = (1 << CW) - 1;

   localparam int PH_IDLE = 0, PH_CRST = 1, PH_RUN = 2, PH_DONE = 3, PH_ERR = 4;

   logic          CLK, RESET, Start;
   logic          Busy, Done, Error;
   logic [CW-1:0] Run_cycles;
   logic          Host_req, Host_we, Host_grant, Host_rvalid;
   logic [AW-1:0] Host_addr;
   logic [DW-1:0] Host_wdata, Host_rdata;
   logic          Core_reset, Core_run, Core_halt, Core_we;
   logic [AW-1:0] Core_addr;
   logic [DW-1:0] Core_wdata, Core_rdata;
   logic [AW-1:0] Mem_addr;
   logic [DW-1:0] Mem_wdata, Mem_rdata;
   logic          Mem_we;

   asip_run_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .RST_CYCLES(RSTC), .WDT_CYCLES(WDT), .CNT_W(CW)
   ) dut (
      .CLK(CLK), .RESET(RESET), .Start(Start),
      .Busy(Busy), .Done(Done), .Error(Error), .Run_cycles(Run_cycles),
      .Host_req(Host_req), .Host_we(Host_we), .Host_addr(Host_addr),
      .Host_wdata(Host_wdata), .Host_grant(Host_grant), .Host_rdata(Host_rdata),
      .Host_rvalid(Host_rvalid), .Core_reset(Core_reset), .Core_run(Core_run),
      .Core_halt(Core_halt), .Core_addr(Core_addr), .Core_wdata(Core_wdata),
      .Core_we(Core_we), .Core_rdata(Core_rdata), .Mem_addr(Mem_addr),
      .Mem_wdata(Mem_wdata), .Mem_we(Mem_we), .Mem_rdata(Mem_rdata)
   );

   // Memory macro: synchronous read, one cycle latency, read-before-write.
   logic [DW-1:0] mem [256];
   always @(posedge CLK) begin
      Mem_rdata <= mem[Mem_addr];
      if (Mem_we) mem[Mem_addr] <= Mem_wdata;
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural job model
   int            m_ph;
   int            m_rst_left;
   int            m_runs;
   logic          m_rvalid;
   logic [DW-1:0] m_rdata;
   logic [DW-1:0] m_mrd;
   logic [DW-1:0] ref_mem [256];

   task automatic model_step();
      logic          host, grant, mwe;
      logic [AW-1:0] maddr;
      logic [DW-1:0] mwd, rd_now;
      host  = (m_ph == PH_IDLE) || (m_ph == PH_DONE) || (m_ph == PH_ERR);
      grant = host && Host_req && !RESET;
      maddr = host ? Host_addr : Core_addr;
      mwd   = host ? Host_wdata : Core_wdata;
      mwe   = !RESET && (host ? (Host_req && Host_we) : ((m_ph == PH_RUN) && Core_we));

      chk("busy",       32'(Busy),        32'((m_ph == PH_CRST) || (m_ph == PH_RUN)));
      chk("done",       32'(Done),        32'(m_ph == PH_DONE));
      chk("error",      32'(Error),       32'(m_ph == PH_ERR));
      chk("core_reset", 32'(Core_reset),  32'((m_ph == PH_IDLE) || (m_ph == PH_CRST)));
      chk("core_run",   32'(Core_run),    32'(m_ph == PH_RUN));
      chk("run_cycles", 32'(Run_cycles),  32'(m_runs));
      chk("host_grant", 32'(Host_grant),  32'(grant));
      chk("host_rvalid",32'(Host_rvalid), 32'(m_rvalid));
      chk("host_rdata", 32'(Host_rdata),  32'(m_rdata));
      chk("mem_addr",   32'(Mem_addr),    32'(maddr));
      chk("mem_we",     32'(Mem_we),      32'(mwe));
      if (mwe) chk("mem_wdata", 32'(Mem_wdata), 32'(mwd));
      chk("core_rdata", 32'(Core_rdata),  32'(m_mrd));

      rd_now = ref_mem[maddr];
      if (mwe) ref_mem[maddr] = mwd;
      if (RESET) begin
         m_ph     = PH_IDLE;
         m_runs   = 0;
         m_rvalid = 1'b0;
         m_rdata  = '0;
      end else begin
         if (grant) begin
            m_rvalid = !Host_we;
            if (!Host_we) m_rdata = rd_now;
         end
         if (host) begin
            if (Start) begin
               m_ph       = PH_CRST;
               m_rst_left = RSTC;
               m_runs     = 0;
            end
         end else if (m_ph == PH_CRST) begin
            m_rst_left--;
            if (m_rst_left == 0) m_ph = PH_RUN;
         end else begin
            if (m_runs < CNT_MAX) m_runs++;
            if (Core_halt) m_ph = PH_DONE;
            else if (m_runs >= WDT) m_ph = PH_ERR;
         end
      end
      m_mrd = rd_now;
   endtask

   task automatic tick();
      @(negedge CLK);
      model_step();
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic          req;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          e_grant;
      logic          e_we;
      logic          e_rvalid;
      logic [DW-1:0] e_rdata;
   } hvec_t;

   hvec_t tbl [7];

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      Mem_rdata  = '0;
      m_ph       = PH_IDLE;
      m_rst_left = 0;
      m_runs     = 0;
      m_rvalid   = 1'b0;
      m_rdata    = '0;
      m_mrd      = '0;

      RESET = 1'b1; Start = 1'b0;
      Host_req = 1'b0; Host_we = 1'b0; Host_addr = '0; Host_wdata = '0;
      Core_halt = 1'b0; Core_we = 1'b0; Core_addr = '0; Core_wdata = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_core_reset", 32'(Core_reset), 32'd1);
      chk("rst_busy",       32'(Busy),       32'd0);
      chk("rst_run_cycles", 32'(Run_cycles), 32'd0);
      tick();
      RESET = 1'b0;

      // Host write then read of 0x40 in IDLE, then hold/overwrite behaviour
      tbl[0] = '{1'b1, 1'b1, 8'h40, 8'h05, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05};
      tbl[4] = '{1'b1, 1'b1, 8'h41, 8'h77, 1'b1, 1'b1, 1'b1, 8'h05};
      tbl[5] = '{1'b1, 1'b0, 8'h41, 8'h00, 1'b1, 1'b0, 1'b0, 8'h05};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77};
      for (int i = 0; i < 7; i++) begin
         Host_req = tbl[i].req; Host_we = tbl[i].we;
         Host_addr = tbl[i].addr; Host_wdata = tbl[i].wdata;
         #1;
         chk("tbl_grant",  32'(Host_grant),  32'(tbl[i].e_grant));
         chk("tbl_mem_we", 32'(Mem_we),      32'(tbl[i].e_we));
         chk("tbl_rvalid", 32'(Host_rvalid), 32'(tbl[i].e_rvalid));
         chk("tbl_rdata",  32'(Host_rdata),  32'(tbl[i].e_rdata));
         tick();
      end
      Host_req = 1'b0;

      // Job halting after 37 RUN cycles, host blocked and core write mid-run
      Start = 1'b1; tick(); Start = 1'b0;
      for (int i = 0; i < int'(RSTC); i++) begin
         chk("crst_busy",  32'(Busy),       32'd1);
         chk("crst_reset", 32'(Core_reset), 32'd1);
         chk("crst_run",   32'(Core_run),   32'd0);
         tick();
      end
      for (int i = 1; i <= 37; i++) begin
         chk("run_en", 32'(Core_run), 32'd1);
         Core_halt  = (i == 37);
         Host_req   = (i == 10);
         Host_we    = 1'b0;
         Host_addr  = 8'h80;
         Core_we    = (i == 12);
         Core_addr  = (i == 12) ? 8'h80 : 8'(i);
         Core_wdata = 8'h2A;
         #1;
         if (i == 10) chk("grant_in_run", 32'(Host_grant), 32'd0);
         if (i == 12) begin
            chk("core_mem_we",   32'(Mem_we),   32'd1);
            chk("core_mem_addr", 32'(Mem_addr), 32'h80);
         end
         tick();
      end
      Core_halt = 1'b0; Host_req = 1'b0; Core_we = 1'b0;
      chk("halt_done",   32'(Done),       32'd1);
      chk("halt_busy",   32'(Busy),       32'd0);
      chk("halt_cycles", 32'(Run_cycles), 32'd37);
      Host_req = 1'b1; Host_we = 1'b0; Host_addr = 8'h80;
      tick();
      Host_req = 1'b0;
      chk("readback_rvalid", 32'(Host_rvalid), 32'd1);
      chk("readback_rdata",  32'(Host_rdata),  32'h2A);

      // Watchdog abort, then restart from ERR
      Start = 1'b1; tick(); Start = 1'b0;
      repeat (RSTC) tick();
      for (int i = 1; i <= int'(WDT); i++) begin
         chk("wdt_running", 32'(Core_run), 32'd1);
         tick();
      end
      chk("wdt_error",  32'(Error),      32'd1);
      chk("wdt_run",    32'(Core_run),   32'd0);
      chk("wdt_cycles", 32'(Run_cycles), 32'(WDT));
      Start = 1'b1; tick(); Start = 1'b0;
      chk("restart_busy",   32'(Busy),       32'd1);
      chk("restart_cycles", 32'(Run_cycles), 32'd0);
      chk("restart_error",  32'(Error),      32'd0);

      // RESET in the 5th RUN cycle aborts without writing memory
      repeat (RSTC) tick();
      repeat (4) tick();
      RESET = 1'b1; Core_we = 1'b1; Core_addr = 8'h90; Core_wdata = 8'h55;
      #1;
      chk("rst_no_write", 32'(Mem_we), 32'd0);
      tick();
      RESET = 1'b0; Core_we = 1'b0;
      chk("abort_core_reset", 32'(Core_reset), 32'd1);
      chk("abort_cycles",     32'(Run_cycles), 32'd0);
      chk("abort_done",       32'(Done),       32'd0);
      chk("abort_error",      32'(Error),      32'd0);
      Host_req = 1'b1; Host_we = 1'b0; Host_addr = 8'h90;
      tick();
      Host_req = 1'b0;
      chk("abort_mem_untouched", 32'(Host_rdata), 32'h00);

      // Halt coincident with watchdog wins; Start during a job is ignored
      Start = 1'b1; tick();
      tick(); Start = 1'b0;
      tick();
      for (int i = 1; i <= int'(WDT); i++) begin
         Start     = (i == 3);
         Core_halt = (i == int'(WDT));
         tick();
      end
      Start = 1'b0; Core_halt = 1'b0;
      chk("tie_done",   32'(Done),       32'd1);
      chk("tie_error",  32'(Error),      32'd0);
      chk("tie_cycles", 32'(Run_cycles), 32'(WDT));

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         RESET      = ($urandom_range(199) == 0);
         Start      = ($urandom_range(15) == 0);
         Core_halt  = ($urandom_range(29) == 0);
         Host_req   = 1'($urandom_range(1));
         Host_we    = 1'($urandom_range(1));
         Host_addr  = 8'($urandom_range(15));
         Host_wdata = 8'($urandom);
         Core_we    = 1'($urandom_range(1));
         Core_addr  = 8'($urandom_range(15));
         Core_wdata = 8'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
